// File: rtl/axi_mem_responder_pkg.sv
// Shared AXI encodings, FSM state types and address helpers for the memory responder.
package axi_mem_responder_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_DATA
  } r_state_e;

  // Address of the following beat; FIXED holds, everything else steps by the transfer size.
  function automatic logic [31:0] axi_next_addr(input logic [31:0] addr,
                                                input logic [2:0]  size,
                                                input logic [1:0]  burst);
    if (burst == BURST_FIXED) return addr;
    return addr + (32'd1 << size);
  endfunction

  // Bursts other than FIXED/INCR, or transfers wider than the 32-bit data bus, are refused.
  function automatic logic axi_cfg_error(input logic [1:0] burst, input logic [2:0] size);
    return !(burst == BURST_FIXED || burst == BURST_INCR) || (size > 3'd2);
  endfunction

endpackage

// File: rtl/axi_mem_responder_bank.sv
// Byte-enabled word array: one synchronous write port, one combinational read port.
module axi_mem_bank #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned AW          = 12
) (
  input  logic          clk_i,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [3:0]    wstrb,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Commit only the byte lanes whose strobe is set; contents are never reset.
  always_ff @(posedge clk_i) begin
    if (we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave that terminates a master bus onto an internal memory bank.
// Independent write and read FSMs; FIXED/INCR bursts; per-beat OKAY/SLVERR/DECERR.
module axi_mem_responder
  import axi_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned RD_LATENCY  = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  output logic [3:0]  bid,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic [3:0]  rid
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
  localparam logic [7:0]  LAT_INIT = 8'(RD_LATENCY - 1);

  function automatic logic in_range(input logic [31:0] a);
    return (a - BASE_ADDR) < SPAN;
  endfunction

  function automatic logic [AW-1:0] word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return AW'(off >> 2);
  endfunction

  // ---------------- write channel ----------------
  w_state_e    w_state, w_state_nx;
  logic [31:0] w_addr;
  logic [3:0]  w_id;
  logic [7:0]  w_len, w_cnt;
  logic [2:0]  w_size;
  logic [1:0]  w_burst;
  logic        w_cfg_err, w_dec_err, w_last_err;
  logic        aw_hs, w_hs, w_beat_last, w_beat_dec, w_beat_last_err, mem_we;
  axi_resp_e   w_final_resp;

  assign aw_hs           = awvalid && awready;
  assign w_hs            = wvalid && wready;
  assign w_beat_last     = (w_cnt == w_len);
  assign w_beat_dec      = !in_range(w_addr);
  assign w_beat_last_err = (wlast != w_beat_last);
  assign mem_we          = w_hs && !w_beat_dec && !w_cfg_err;

  // Worst response over the burst, folding in the beat currently being accepted.
  always_comb begin
    w_final_resp = RESP_OKAY;
    if (w_dec_err || w_beat_dec)                         w_final_resp = RESP_DECERR;
    else if (w_cfg_err || w_last_err || w_beat_last_err) w_final_resp = RESP_SLVERR;
  end

  // Write FSM next state; the beat count, not wlast, ends the burst.
  always_comb begin
    w_state_nx = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_state_nx = W_DATA;
      W_DATA:  if (w_hs && w_beat_last) w_state_nx = W_RESP;
      W_RESP:  if (bvalid && bready) w_state_nx = W_IDLE;
      default: w_state_nx = W_IDLE;
    endcase
  end

  // Write state register; handshake outputs are registered copies of the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
    end else begin
      w_state <= w_state_nx;
      awready <= (w_state_nx == W_IDLE);
      wready  <= (w_state_nx == W_DATA);
      bvalid  <= (w_state_nx == W_RESP);
    end
  end

  // Write request latch, address generator, error accumulation and B payload.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_addr     <= '0;
      w_id       <= '0;
      w_len      <= '0;
      w_cnt      <= '0;
      w_size     <= '0;
      w_burst    <= '0;
      w_cfg_err  <= 1'b0;
      w_dec_err  <= 1'b0;
      w_last_err <= 1'b0;
      bresp      <= '0;
      bid        <= '0;
    end else if (aw_hs) begin
      w_addr     <= awaddr;
      w_id       <= awid;
      w_len      <= awlen;
      w_cnt      <= '0;
      w_size     <= awsize;
      w_burst    <= awburst;
      w_cfg_err  <= axi_cfg_error(awburst, awsize);
      w_dec_err  <= 1'b0;
      w_last_err <= 1'b0;
    end else if (w_hs) begin
      w_addr     <= axi_next_addr(w_addr, w_size, w_burst);
      w_cnt      <= w_cnt + 8'd1;
      w_dec_err  <= w_dec_err | w_beat_dec;
      w_last_err <= w_last_err | w_beat_last_err;
      if (w_beat_last) begin
        bresp <= w_final_resp;
        bid   <= w_id;
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_e    r_state, r_state_nx;
  logic [31:0] r_addr, r_addr_nx;
  logic [7:0]  r_len, r_cnt, r_lat;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic        r_cfg_err;
  logic        ar_hs, r_hs, r_last_now;
  logic        r_load, l_cfg_err, l_dec, l_last;
  logic [31:0] l_addr, bank_rdata;

  assign ar_hs      = arvalid && arready;
  assign r_hs       = rvalid && rready;
  assign r_last_now = (r_cnt == r_len);
  assign r_addr_nx  = axi_next_addr(r_addr, r_size, r_burst);
  assign l_dec      = !in_range(l_addr);

  // R payload is registered, so the bank is looked up one cycle ahead: from the
  // AR inputs, from the latched address while waiting, or from the next beat's address.
  always_comb begin
    r_load    = 1'b0;
    l_addr    = r_addr;
    l_cfg_err = r_cfg_err;
    l_last    = (r_len == 8'd0);
    case (r_state)
      R_IDLE: begin
        l_addr    = araddr;
        l_cfg_err = axi_cfg_error(arburst, arsize);
        l_last    = (arlen == 8'd0);
        r_load    = ar_hs && (RD_LATENCY == 1);
      end
      R_WAIT: r_load = (r_lat <= 8'd1);
      R_DATA: begin
        l_addr = r_addr_nx;
        l_last = (8'(r_cnt + 8'd1) == r_len);
        r_load = r_hs && !r_last_now;
      end
      default: r_load = 1'b0;
    endcase
  end

  // Read FSM next state.
  always_comb begin
    r_state_nx = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nx = (RD_LATENCY == 1) ? R_DATA : R_WAIT;
      R_WAIT:  if (r_lat <= 8'd1) r_state_nx = R_DATA;
      R_DATA:  if (r_hs && r_last_now) r_state_nx = R_IDLE;
      default: r_state_nx = R_IDLE;
    endcase
  end

  // Read state register with registered handshake outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
    end else begin
      r_state <= r_state_nx;
      arready <= (r_state_nx == R_IDLE);
      rvalid  <= (r_state_nx == R_DATA);
    end
  end

  // Read request latch, latency counter, address generator and R payload.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_lat     <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_cfg_err <= 1'b0;
      rid       <= '0;
      rdata     <= '0;
      rresp     <= '0;
      rlast     <= 1'b0;
    end else begin
      if (ar_hs) begin
        r_addr    <= araddr;
        r_len     <= arlen;
        r_cnt     <= '0;
        r_lat     <= LAT_INIT;
        r_size    <= arsize;
        r_burst   <= arburst;
        r_cfg_err <= axi_cfg_error(arburst, arsize);
        rid       <= arid;
      end else if (r_state == R_WAIT) begin
        r_lat <= r_lat - 8'd1;
      end else if (r_hs && !r_last_now) begin
        r_addr <= r_addr_nx;
        r_cnt  <= r_cnt + 8'd1;
      end
      if (r_load) begin
        rdata <= (l_dec || l_cfg_err) ? 32'h0 : bank_rdata;
        rresp <= l_dec ? RESP_DECERR : (l_cfg_err ? RESP_SLVERR : RESP_OKAY);
        rlast <= l_last;
      end
    end
  end

  axi_mem_bank #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_bank (
    .clk_i(clk_i),
    .we   (mem_we),
    .waddr(word_of(w_addr)),
    .wstrb(wstrb),
    .wdata(wdata),
    .raddr(word_of(l_addr)),
    .rdata(bank_rdata)
  );

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: bus tasks drive AXI traffic, test tasks check results.
module tb_axi_mem_responder;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        awvalid = 1'b0, awready;
  logic [31:0] awaddr = '0;
  logic [3:0]  awid = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = 3'd2;
  logic [1:0]  awburst = 2'b01;
  logic        wvalid = 1'b0, wready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        bvalid, bready = 1'b0;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arvalid = 1'b0, arready;
  logic [31:0] araddr = '0;
  logic [3:0]  arid = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = 3'd2;
  logic [1:0]  arburst = 2'b01;
  logic        rvalid, rready = 1'b0;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] wbuf [8];
  logic [3:0]  sbuf [8];
  logic [31:0] rbuf [8];
  logic [1:0]  rrbuf [8];
  logic        rlbuf [8];

  logic [1:0]  t_resp;
  logic [3:0]  t_id;
  logic        t_prompt, t_ok;
  int          t_first, t_holds;

  always #5 clk_i = ~clk_i;

  axi_mem_responder #(
    .DEPTH_WORDS(4096),
    .BASE_ADDR  (32'h8000_0000),
    .RD_LATENCY (1)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rid(rid)
  );

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Full write transaction from a negedge. last_at is the beat index that carries wlast.
  task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size, input int last_at,
                           output logic [1:0] resp, output logic [3:0] id_o,
                           output logic prompt, output logic ok);
    int n;
    ok = 1'b1;
    awaddr = addr; awid = id; awlen = len; awburst = burst; awsize = size; awvalid = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < 50) begin @(negedge clk_i); n++; end
    if (n >= 50) ok = 1'b0;
    @(posedge clk_i); @(negedge clk_i);
    awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      wvalid = 1'b1; wdata = wbuf[b]; wstrb = sbuf[b]; wlast = (b == last_at);
      n = 0;
      while (wready !== 1'b1 && n < 50) begin @(negedge clk_i); n++; end
      if (n >= 50) ok = 1'b0;
      @(posedge clk_i); @(negedge clk_i);
    end
    wvalid = 1'b0; wlast = 1'b0;
    prompt = bvalid;
    bready = 1'b1;
    n = 0;
    while (bvalid !== 1'b1 && n < 50) begin @(negedge clk_i); n++; end
    if (n >= 50) ok = 1'b0;
    resp = bresp; id_o = bid;
    @(posedge clk_i); @(negedge clk_i);
    bready = 1'b0;
  endtask

  // Full read transaction from a negedge; toggle stalls rready on every other cycle.
  task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size, input logic toggle,
                          output logic [3:0] id_o, output int first, output int holds,
                          output logic ok);
    int n, beat, cyc;
    logic stalled;
    logic [31:0] hd;
    logic [1:0] hr;
    logic hl;
    ok = 1'b1; first = -1; holds = 0; id_o = 'x;
    stalled = 1'b0; hd = '0; hr = '0; hl = 1'b0;
    araddr = addr; arid = id; arlen = len; arburst = burst; arsize = size; arvalid = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 50) begin @(negedge clk_i); n++; end
    if (n >= 50) ok = 1'b0;
    @(posedge clk_i); @(negedge clk_i);
    arvalid = 1'b0;
    beat = 0; cyc = 0;
    while (beat <= int'(len) && cyc < 100) begin
      rready = toggle ? (cyc % 2 == 1) : 1'b1;
      if (rvalid === 1'b1) begin
        if (first < 0) first = cyc;
        if (stalled && (rdata !== hd || rresp !== hr || rlast !== hl)) holds++;
        if (rready) begin
          rbuf[beat] = rdata; rrbuf[beat] = rresp; rlbuf[beat] = rlast; id_o = rid;
          beat++; stalled = 1'b0;
        end else begin
          stalled = 1'b1; hd = rdata; hr = rresp; hl = rlast;
        end
      end
      @(posedge clk_i); @(negedge clk_i);
      cyc++;
    end
    rready = 1'b0;
    if (beat <= int'(len)) ok = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_i);
    n_cmp++;
    if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_handshakes: got %b want 000000", {awready, wready, bvalid, arready, rvalid, rlast});
    end
    n_cmp++;
    if ({bresp, bid, rresp, rid, rdata} !== 44'h0) begin
      n_fail++;
      $display("FAIL reset_payload: got %h want 0", {bresp, bid, rresp, rid, rdata});
    end
    rst_ni = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    n_cmp++;
    if ({awready, arready, wready, rvalid} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b want 1100", {awready, arready, wready, rvalid});
    end
  endtask

  task automatic test_single();
    wbuf[0] = 32'hDEAD_BEEF; sbuf[0] = 4'hF;
    axi_write(32'h8000_0010, 4'h3, 8'd0, 2'b01, 3'd2, 0, t_resp, t_id, t_prompt, t_ok);
    n_cmp++;
    if ({t_ok, t_prompt, t_resp, t_id} !== {1'b1, 1'b1, 2'b00, 4'h3}) begin
      n_fail++;
      $display("FAIL single_write_b: got ok/prompt/resp/id %b/%b/%h/%h want 1/1/0/3", t_ok, t_prompt, t_resp, t_id);
    end
    axi_read(32'h8000_0010, 4'h5, 8'd0, 2'b01, 3'd2, 1'b0, t_id, t_first, t_holds, t_ok);
    n_cmp++;
    if ({t_ok, rbuf[0], rrbuf[0], rlbuf[0], t_id} !== {1'b1, 32'hDEAD_BEEF, 2'b00, 1'b1, 4'h5}) begin
      n_fail++;
      $display("FAIL single_read: got data %h resp %h last %b id %h want deadbeef 0 1 5", rbuf[0], rrbuf[0], rlbuf[0], t_id);
    end
    n_cmp++;
    if (t_first !== 0) begin
      n_fail++;
      $display("FAIL single_read_latency: got %0d want 0 extra cycles", t_first);
    end
  endtask

  task automatic test_incr_burst();
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; end
    axi_write(32'h8000_0100, 4'h1, 8'd3, 2'b01, 3'd2, 3, t_resp, t_id, t_prompt, t_ok);
    n_cmp++;
    if ({t_ok, t_prompt, t_resp} !== 4'b1100) begin
      n_fail++;
      $display("FAIL incr_write_b: got ok/prompt/resp %b/%b/%h want 1/1/0", t_ok, t_prompt, t_resp);
    end
    axi_read(32'h8000_0100, 4'h2, 8'd3, 2'b01, 3'd2, 1'b1, t_id, t_first, t_holds, t_ok);
    n_cmp++;
    if ({rbuf[0], rbuf[1], rbuf[2], rbuf[3]} !== {32'd1, 32'd2, 32'd3, 32'd4}) begin
      n_fail++;
      $display("FAIL incr_read_data: got %h %h %h %h want 1 2 3 4", rbuf[0], rbuf[1], rbuf[2], rbuf[3]);
    end
    n_cmp++;
    if ({t_ok, rlbuf[0], rlbuf[1], rlbuf[2], rlbuf[3]} !== 5'b10001) begin
      n_fail++;
      $display("FAIL incr_read_rlast: got ok %b last %b%b%b%b want 1 0001", t_ok, rlbuf[0], rlbuf[1], rlbuf[2], rlbuf[3]);
    end
    n_cmp++;
    if (t_holds !== 0) begin
      n_fail++;
      $display("FAIL incr_read_hold: got %0d stall changes want 0", t_holds);
    end
  endtask

  task automatic test_fixed_burst();
    wbuf[0] = 32'h0000_0504; sbuf[0] = 4'hF;
    axi_write(32'h8000_0504, 4'h0, 8'd0, 2'b01, 3'd2, 0, t_resp, t_id, t_prompt, t_ok);
    wbuf[0] = 32'h0000_000A; wbuf[1] = 32'h0000_000B; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
    axi_write(32'h8000_0500, 4'h6, 8'd1, 2'b00, 3'd2, 1, t_resp, t_id, t_prompt, t_ok);
    n_cmp++;
    if ({t_resp, t_id} !== {2'b00, 4'h6}) begin
      n_fail++;
      $display("FAIL fixed_write_b: got resp %h id %h want 0 6", t_resp, t_id);
    end
    axi_read(32'h8000_0500, 4'h7, 8'd1, 2'b01, 3'd2, 1'b0, t_id, t_first, t_holds, t_ok);
    n_cmp++;
    if ({rbuf[0], rbuf[1]} !== {32'h0000_000B, 32'h0000_0504}) begin
      n_fail++;
      $display("FAIL fixed_write_mem: got %h %h want 0000000b 00000504", rbuf[0], rbuf[1]);
    end
    axi_read(32'h8000_0100, 4'h7, 8'd1, 2'b00, 3'd2, 1'b0, t_id, t_first, t_holds, t_ok);
    n_cmp++;
    if ({rbuf[0], rbuf[1], rlbuf[0], rlbuf[1]} !== {32'd1, 32'd1, 2'b01}) begin
      n_fail++;
      $display("FAIL fixed_read: got %h %h last %b%b want 1 1 01", rbuf[0], rbuf[1], rlbuf[0], rlbuf[1]);
    end
  endtask

  task automatic test_strobes();
    wbuf[0] = 32'h1122_3344; sbuf[0] = 4'hF;
    axi_write(32'h8000_0200, 4'h0, 8'd0, 2'b01, 3'd2, 0, t_resp, t_id, t_prompt, t_ok);
    wbuf[0] = 32'hAABB_CCDD; sbuf[0] = 4'b0101;
    axi_write(32'h8000_0200, 4'h0, 8'd0, 2'b01, 3'd2, 0, t_resp, t_id, t_prompt, t_ok);
    axi_read(32'h8000_0200, 4'h0, 8'd0, 2'b01, 3'd2, 1'b0, t_id, t_first, t_holds, t_ok);
    n_cmp++;
    if (rbuf[0] !== 32'h11BB_33DD) begin
      n_fail++;
      $display("FAIL strobe_merge: got %h want 11bb33dd", rbuf[0]);
    end
  endtask

  task automatic test_decerr();
    wbuf[0] = 32'hCAFE_F00D; sbuf[0] = 4'hF;
    axi_write(32'h8000_0000, 4'h0, 8'd0, 2'b01, 3'd2, 0, t_resp, t_id, t_prompt, t_ok);
    axi_read(32'h0000_0000, 4'hA, 8'd1, 2'b01, 3'd2, 1'b0, t_id, t_first, t_holds, t_ok);
    n_cmp++;
    if ({t_ok, rbuf[0], rbuf[1], rrbuf[0], rrbuf[1], t_id} !== {1'b1, 64'h0, 4'b1111, 4'hA}) begin
      n_fail++;
      $display("FAIL decerr_read: got %h %h resp %h %h id %h want 0 0 3 3 a", rbuf[0], rbuf[1], rrbuf[0], rrbuf[1], t_id);
    end
    wbuf[0] = 32'h1234_5678; sbuf[0] = 4'hF;
    axi_write(32'h0000_0000, 4'hB, 8'd0, 2'b01, 3'd2, 0, t_resp, t_id, t_prompt, t_ok);
    n_cmp++;
    if ({t_resp, t_id} !== {2'b11, 4'hB}) begin
      n_fail++;
      $display("FAIL decerr_write_b: got resp %h id %h want 3 b", t_resp, t_id);
    end
    axi_read(32'h8000_0000, 4'h0, 8'd0, 2'b01, 3'd2, 1'b0, t_id, t_first, t_holds, t_ok);
    n_cmp++;
    if (rbuf[0] !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL decerr_write_dropped: got %h want cafef00d", rbuf[0]);
    end
    wbuf[0] = 32'h0BAD_CAFE; sbuf[0] = 4'hF;
    axi_write(32'h8000_3FFC, 4'h0, 8'd0, 2'b01, 3'd2, 0, t_resp, t_id, t_prompt, t_ok);
    axi_read(32'h8000_3FFC, 4'h0, 8'd1, 2'b01, 3'd2, 1'b0, t_id, t_first, t_holds, t_ok);
    n_cmp++;
    if ({rbuf[0], rrbuf[0], rbuf[1], rrbuf[1]} !== {32'h0BAD_CAFE, 2'b00, 32'h0, 2'b11}) begin
      n_fail++;
      $display("FAIL top_boundary: got %h/%h %h/%h want 0badcafe/0 0/3", rbuf[0], rrbuf[0], rbuf[1], rrbuf[1]);
    end
  endtask

  task automatic test_errors();
    wbuf[0] = 32'h5566_7788; sbuf[0] = 4'hF;
    axi_write(32'h8000_0300, 4'h0, 8'd0, 2'b01, 3'd2, 0, t_resp, t_id, t_prompt, t_ok);
    for (int i = 0; i < 3; i++) begin wbuf[i] = 32'h9999_9999; sbuf[i] = 4'hF; end
    axi_write(32'h8000_0300, 4'hC, 8'd2, 2'b10, 3'd2, 2, t_resp, t_id, t_prompt, t_ok);
    n_cmp++;
    if ({t_ok, t_prompt, t_resp, t_id} !== {1'b1, 1'b1, 2'b10, 4'hC}) begin
      n_fail++;
      $display("FAIL wrap_write_b: got ok/prompt/resp/id %b/%b/%h/%h want 1/1/2/c", t_ok, t_prompt, t_resp, t_id);
    end
    axi_read(32'h8000_0300, 4'h0, 8'd0, 2'b01, 3'd2, 1'b0, t_id, t_first, t_holds, t_ok);
    n_cmp++;
    if (rbuf[0] !== 32'h5566_7788) begin
      n_fail++;
      $display("FAIL wrap_write_dropped: got %h want 55667788", rbuf[0]);
    end
    axi_write(32'h8000_0400, 4'hD, 8'd2, 2'b01, 3'd2, 1, t_resp, t_id, t_prompt, t_ok);
    n_cmp++;
    if ({t_ok, t_prompt, t_resp} !== 4'b1110) begin
      n_fail++;
      $display("FAIL early_wlast: got ok/prompt/resp %b/%b/%h want 1/1/2", t_ok, t_prompt, t_resp);
    end
    axi_write(32'h8000_0400, 4'hD, 8'd1, 2'b01, 3'd2, 5, t_resp, t_id, t_prompt, t_ok);
    n_cmp++;
    if ({t_ok, t_prompt, t_resp} !== 4'b1110) begin
      n_fail++;
      $display("FAIL missing_wlast: got ok/prompt/resp %b/%b/%h want 1/1/2", t_ok, t_prompt, t_resp);
    end
    axi_read(32'h8000_0100, 4'hE, 8'd0, 2'b01, 3'd3, 1'b0, t_id, t_first, t_holds, t_ok);
    n_cmp++;
    if ({rbuf[0], rrbuf[0], rlbuf[0]} !== {32'h0, 2'b10, 1'b1}) begin
      n_fail++;
      $display("FAIL wide_size_read: got %h resp %h last %b want 0 2 1", rbuf[0], rrbuf[0], rlbuf[0]);
    end
  endtask

  task automatic test_reset_mid_read();
    int beat, n;
    araddr = 32'h8000_0100; arid = 4'h4; arlen = 8'd7; arburst = 2'b01; arsize = 3'd2;
    arvalid = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 50) begin @(negedge clk_i); n++; end
    @(posedge clk_i); @(negedge clk_i);
    arvalid = 1'b0; rready = 1'b1;
    beat = 0; n = 0;
    while (beat < 2 && n < 50) begin
      if (rvalid === 1'b1) beat++;
      @(posedge clk_i); @(negedge clk_i);
      n++;
    end
    n_cmp++;
    if ({rvalid, rdata} !== {1'b1, 32'd3}) begin
      n_fail++;
      $display("FAIL mid_read_beat2: got valid %b data %h want 1 00000003", rvalid, rdata);
    end
    rst_ni = 1'b0; rready = 1'b0;
    #1;
    n_cmp++;
    if ({rvalid, bvalid, rlast} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_drops_valid: got rvalid/bvalid/rlast %b want 000", {rvalid, bvalid, rlast});
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    n_cmp++;
    if (arready !== 1'b0) begin
      n_fail++;
      $display("FAIL arready_at_release: got %b want 0", arready);
    end
    @(posedge clk_i); @(negedge clk_i);
    n_cmp++;
    if (arready !== 1'b1) begin
      n_fail++;
      $display("FAIL arready_after_release: got %b want 1", arready);
    end
    axi_read(32'h8000_0010, 4'h9, 8'd0, 2'b01, 3'd2, 1'b0, t_id, t_first, t_holds, t_ok);
    n_cmp++;
    if ({t_ok, t_id, rbuf[0], rlbuf[0]} !== {1'b1, 4'h9, 32'hDEAD_BEEF, 1'b1}) begin
      n_fail++;
      $display("FAIL post_reset_read: got ok %b id %h data %h last %b want 1 9 deadbeef 1", t_ok, t_id, rbuf[0], rlbuf[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_incr_burst();
    test_fixed_burst();
    test_strobes();
    test_decerr();
    test_errors();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
